// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - FSM state, AXI constants and width helpers for icache_nway
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        MISS_R,
        UNC_AR,
        UNC_R,
        RESP
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // A 1-entry dimension still needs a 1-bit selector.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_OFF_W = $clog2(8);
    localparam int DEF_IDX_W = $clog2(128);
    localparam int DEF_WAY_W = width_of(2);

endpackage

// File: rtl/icache_nway_if.sv
// rtl/icache_nway_if.sv - fetch-side and AXI read-side bundles for icache_nway
interface icache_sram_if;
    logic        sram_req;
    logic [31:0] sram_addr;
    logic        sram_cache;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    modport master (output sram_req, sram_addr, sram_cache,
                    input  sram_addr_ok, sram_data_ok, sram_rdata);
    modport slave  (input  sram_req, sram_addr, sram_cache,
                    output sram_addr_ok, sram_data_ok, sram_rdata);
endinterface

interface icache_axi_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                    input  arready, rdata, rresp, rlast, rvalid);
    modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                    output arready, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/icache_way_ram.sv
// rtl/icache_way_ram.sv - one cache way: tag + line data, synchronous read, per-word write enable
module icache_way_ram #(
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 7,
    parameter int TAG_W      = 20
) (
    input  logic                         clk,
    input  logic                         rd_en,
    input  logic [IDX_W-1:0]             rd_index,
    input  logic [IDX_W-1:0]             wr_index,
    input  logic                         tag_we,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_WORDS-1:0]        word_we,
    input  logic [31:0]                  wr_data,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [LINE_WORDS-1:0][31:0]  rd_line
);

    logic [TAG_W-1:0]            tag_mem  [SETS];
    logic [LINE_WORDS-1:0][31:0] data_mem [SETS];

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (word_we[w]) begin
                data_mem[wr_index][w] <= wr_data;
            end
        end
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_index];
            rd_line <= data_mem[rd_index];
        end
    end

endmodule

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - set-associative read-only I-cache, round-robin refill; ICACHE_INV_EN adds set invalidate
module icache_nway
    import icache_pkg::*;
#(
    parameter int         WAYS       = 2,
    parameter int         SETS       = 128,
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    icache_sram_if.slave            sram,
    icache_axi_if.master            axi
`ifdef ICACHE_INV_EN
    ,
    input  logic                    inv_req,
    input  logic [$clog2(SETS)-1:0] inv_index,
    output logic                    inv_ack
`endif
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_W   = 32 - IDX_LSB - IDX_W;
    localparam int WAY_W   = width_of(WAYS);
    localparam int BEAT_W  = OFF_W + 1;

    state_t                      state;
    logic [31:2]                 req_addr;
    logic                        req_cache;
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAY_W-1:0]            rr_ptr  [SETS];
    logic [WAY_W-1:0]            victim;
    logic [BEAT_W-1:0]           beat;
    logic                        err;
    logic [31:0]                 resp_word;

    logic [TAG_W-1:0]            rd_tag  [WAYS];
    logic [LINE_WORDS-1:0][31:0] rd_line [WAYS];

    logic [IDX_W-1:0]  req_index, acc_index;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_word;
    logic              hit, accept, inv_go, fill_beat, beat_ok, fill_err;
    logic [31:0]       hit_word;
    logic              addr_ok, data_ok;
    logic [31:0]       rdata;
    logic [LINE_WORDS-1:0] word_sel;
    logic [WAY_W-1:0]  rr_next;
    state_t            after_accept;
    logic              unused_ok;

    assign req_index = req_addr[IDX_LSB +: IDX_W];
    assign req_tag   = req_addr[31 -: TAG_W];
    assign req_word  = req_addr[2 +: OFF_W];
    assign acc_index = sram.sram_addr[IDX_LSB +: IDX_W];
    assign unused_ok = ^sram.sram_addr[1:0];

`ifdef ICACHE_INV_EN
    assign inv_go  = rst && inv_req && (state == IDLE);
    assign inv_ack = inv_go;
`else
    assign inv_go  = 1'b0;
`endif

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_index][w] && rd_tag[w] == req_tag) begin
                hit      = 1'b1;
                hit_word = rd_line[w][req_word];
            end
        end
    end

    // Everything the fetch side sees is forced quiet while reset is held.
    always_comb begin
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        if (rst) begin
            case (state)
                IDLE:    addr_ok = !inv_go;
                LOOKUP:  begin addr_ok = hit; data_ok = hit; rdata = hit ? hit_word : '0; end
                RESP:    begin addr_ok = 1'b1; data_ok = 1'b1; rdata = resp_word; end
                default: ;
            endcase
        end
    end

    assign sram.sram_addr_ok = addr_ok;
    assign sram.sram_data_ok = data_ok;
    assign sram.sram_rdata   = rdata;
    assign accept            = sram.sram_req && addr_ok;
    assign after_accept      = !accept ? IDLE : (sram.sram_cache ? LOOKUP : UNC_AR);

    assign fill_beat = (state == MISS_R) && axi.rvalid;
    assign beat_ok   = !beat[OFF_W];
    assign word_sel  = LINE_WORDS'(1) << beat[OFF_W-1:0];
    // Short bursts, overruns and any non-OKAY beat all leave the line invalid.
    assign fill_err  = err || (axi.rresp != RESP_OKAY) || !beat_ok
                     || (axi.rlast && beat != BEAT_W'(LINE_WORDS - 1));
    assign rr_next   = WAY_W'((WAYS == 1) ? 0 : 32'(rr_ptr[req_index]) + 1);

    assign axi.arid    = AXI_ID;
    assign axi.arvalid = rst && (state == MISS_AR || state == UNC_AR);
    assign axi.araddr  = req_cache ? {req_addr[31:IDX_LSB], IDX_LSB'(0)} : {req_addr, 2'b00};
    assign axi.arlen   = req_cache ? 8'(LINE_WORDS - 1) : 8'd0;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = req_cache ? BURST_INCR : BURST_FIXED;
    assign axi.rready  = 1'b1;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic                  sel;
        logic [LINE_WORDS-1:0] we;
        assign sel = fill_beat && (victim == WAY_W'(w));
        assign we  = (sel && beat_ok) ? word_sel : '0;

        icache_way_ram #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W)
        ) u_ram (
            .clk(clk), .rd_en(accept), .rd_index(acc_index), .wr_index(req_index),
            .tag_we(sel && axi.rlast), .wr_tag(req_tag), .word_we(we),
            .wr_data(axi.rdata), .rd_tag(rd_tag[w]), .rd_line(rd_line[w])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_cache <= 1'b0;
            victim    <= '0;
            beat      <= '0;
            err       <= 1'b0;
            resp_word <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_ptr[s]  <= '0;
            end
        end else begin
            if (accept) begin
                req_addr  <= sram.sram_addr[31:2];
                req_cache <= sram.sram_cache;
            end
            case (state)
                IDLE: begin
`ifdef ICACHE_INV_EN
                    if (inv_go) valid_q[inv_index] <= '0;
`endif
                    state <= after_accept;
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= after_accept;
                    end else begin
                        state  <= MISS_AR;
                        victim <= rr_ptr[req_index];
                        beat   <= '0;
                        err    <= 1'b0;
                    end
                end
                MISS_AR: if (axi.arready) state <= MISS_R;
                MISS_R: begin
                    if (axi.rvalid) begin
                        if (beat_ok) beat <= beat + 1'b1;
                        if (beat_ok && beat[OFF_W-1:0] == req_word) resp_word <= axi.rdata;
                        err <= fill_err;
                        if (axi.rlast) begin
                            valid_q[req_index][victim] <= !fill_err;
                            rr_ptr[req_index]          <= rr_next;
                            state                      <= RESP;
                        end
                    end
                end
                UNC_AR: if (axi.arready) state <= UNC_R;
                UNC_R: begin
                    if (axi.rvalid) begin
                        resp_word <= axi.rdata;
                        state     <= RESP;
                    end
                end
                RESP:    state <= after_accept;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - directed scoreboard bench for icache_nway (ICACHE_INV_EN optional)
module tb_icache_nway;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_sram_if sif ();
    icache_axi_if  aif ();

`ifdef ICACHE_INV_EN
    logic       inv_req = 1'b0;
    logic [6:0] inv_index = '0;
    logic       inv_ack;
`endif

    icache_nway #(.WAYS(2), .SETS(128), .LINE_WORDS(8), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .sram(sif), .axi(aif)
`ifdef ICACHE_INV_EN
        , .inv_req(inv_req), .inv_index(inv_index), .inv_ack(inv_ack)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          ar_count = 0;
    int          beat_cnt = 0;
    int          err_beat = -1;
    int          hold_at  = -1;
    logic [31:0] last_araddr = '0;
    logic [7:0]  last_arlen  = '0;
    logic [1:0]  last_arburst = '0;
    logic [3:0]  last_arid   = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w ^ 32'hA5C3_0F1E) + {w[15:0], w[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        logic [31:0] e;
        check({tag, " data_ok"}, 32'(sif.sram_data_ok), 32'd1);
        if (exp_q.size() == 0) e = 32'hxxxx_xxxx;
        else e = exp_q.pop_front();
        check({tag, " rdata"}, sif.sram_rdata, e);
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic c, input int exp_ar);
        int n0, cyc, lat;
        n0 = ar_count;
        @(posedge clk); #1;
        sif.sram_req = 1'b1; sif.sram_addr = a; sif.sram_cache = c;
        cyc = 0;
        @(negedge clk);
        while (sif.sram_addr_ok !== 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
        check({tag, " accept"}, 32'(sif.sram_addr_ok), 32'd1);
        exp_q.push_back(mem_word(a));
        @(posedge clk); #1 sif.sram_req = 1'b0;
        lat = 0;
        @(negedge clk);
        while (sif.sram_data_ok !== 1'b1 && lat < 300) begin lat++; @(negedge clk); end
        check_resp(tag);
        check({tag, " ar_count"}, 32'(ar_count - n0), 32'(exp_ar));
        if (exp_ar == 0) check({tag, " hit latency"}, 32'(lat), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0; sif.sram_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
    endtask

    // AXI read slave: memory contents are mem_word(address); beats can be errored or stalled.
    initial begin
        int          beats;
        logic [31:0] base;
        logic        fixed;
        aif.arready = 1'b0; aif.rvalid = 1'b0; aif.rdata = '0; aif.rresp = '0; aif.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && aif.arvalid) begin
                ar_count++;
                last_araddr = aif.araddr; last_arlen = aif.arlen;
                last_arburst = aif.arburst; last_arid = aif.arid;
                beats = int'(aif.arlen) + 1;
                base  = aif.araddr;
                fixed = (aif.arburst == BURST_FIXED);
                aif.arready = 1'b1;
                @(posedge clk); #1 aif.arready = 1'b0;
                for (int k = 0; k < beats; k++) begin
                    if (k == hold_at) begin
                        aif.rvalid = 1'b0;
                        for (int t = 0; t < 500 && rst; t++) @(posedge clk);
                        break;
                    end
                    aif.rvalid = 1'b1;
                    aif.rdata  = mem_word(fixed ? base : base + 32'(4 * k));
                    aif.rresp  = (k == err_beat) ? 2'b10 : RESP_OKAY;
                    aif.rlast  = (k == beats - 1);
                    @(posedge clk); #1;
                    beat_cnt++;
                    if (!rst) break;
                end
                aif.rvalid = 1'b0; aif.rlast = 1'b0; aif.rresp = RESP_OKAY;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, cyc;
        sif.sram_req = 1'b0; sif.sram_addr = '0; sif.sram_cache = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset addr_ok", 32'(sif.sram_addr_ok), 32'd0);
        check("reset data_ok", 32'(sif.sram_data_ok), 32'd0);
        check("reset rdata", sif.sram_rdata, 32'd0);
        check("reset arvalid", 32'(aif.arvalid), 32'd0);
        check("reset araddr", aif.araddr, 32'd0);
`ifdef ICACHE_INV_EN
        check("reset inv_ack", 32'(inv_ack), 32'd0);
`endif
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("idle addr_ok", 32'(sif.sram_addr_ok), 32'd1);

        fetch("t1 cold", 32'h0000_1008, 1'b1, 1);
        check("t1 araddr", last_araddr, 32'h0000_1000);
        check("t1 arlen", 32'(last_arlen), 32'd7);
        check("t1 arburst", 32'(last_arburst), 32'(BURST_INCR));
        check("t1 arid", 32'(last_arid), 32'd0);
        fetch("t1 refetch", 32'h0000_100C, 1'b1, 0);

        n0 = ar_count;
        @(posedge clk); #1;
        sif.sram_req = 1'b1; sif.sram_cache = 1'b1; sif.sram_addr = 32'h0000_1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t4 addr_ok %0d", i), 32'(sif.sram_addr_ok), 32'd1);
            if (i > 0) check_resp($sformatf("t4 hit %0d", i - 1));
            exp_q.push_back(mem_word(sif.sram_addr));
            @(posedge clk); #1;
            if (i == 7) sif.sram_req = 1'b0;
            else sif.sram_addr = sif.sram_addr + 32'd4;
        end
        @(negedge clk);
        check_resp("t4 hit 7");
        check("t4 no ar", 32'(ar_count - n0), 32'd0);

        fetch("t2 uncached", 32'hBFC0_0004, 1'b0, 1);
        check("t2 araddr", last_araddr, 32'hBFC0_0004);
        check("t2 arlen", 32'(last_arlen), 32'd0);
        check("t2 arburst", 32'(last_arburst), 32'(BURST_FIXED));
        fetch("t2 no allocate", 32'hBFC0_0004, 1'b1, 1);

        do_reset();
        fetch("t3 miss 1000", 32'h0000_1000, 1'b1, 1);
        fetch("t3 miss 2000", 32'h0000_2000, 1'b1, 1);
        fetch("t3 miss 3000", 32'h0000_3000, 1'b1, 1);
        fetch("t3 hit 2000", 32'h0000_2000, 1'b1, 0);
        fetch("t3 evicted 1000", 32'h0000_1000, 1'b1, 1);

        err_beat = 5;
        fetch("t5 error beat", 32'h0000_4054, 1'b1, 1);
        err_beat = -1;
        fetch("t5 line invalid", 32'h0000_4050, 1'b1, 1);
        fetch("t5 clean hit", 32'h0000_405C, 1'b1, 0);

        hold_at = 3;
        n0 = beat_cnt;
        @(posedge clk); #1;
        sif.sram_req = 1'b1; sif.sram_addr = 32'h0000_6000; sif.sram_cache = 1'b1;
        @(negedge clk);
        check("t6 accept", 32'(sif.sram_addr_ok), 32'd1);
        @(posedge clk); #1 sif.sram_req = 1'b0;
        cyc = 0;
        while (beat_cnt - n0 < 3 && cyc < 100) begin @(negedge clk); cyc++; end
        check("t6 beats before reset", 32'(beat_cnt - n0), 32'd3);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t6 arvalid", 32'(aif.arvalid), 32'd0);
        check("t6 data_ok", 32'(sif.sram_data_ok), 32'd0);
        hold_at = -1;
        exp_q.delete();
        fetch("t6 miss after reset", 32'h0000_6000, 1'b1, 1);

`ifdef ICACHE_INV_EN
        fetch("t6 fill 2000", 32'h0000_2000, 1'b1, 1);
        fetch("t6 hit 2000", 32'h0000_2000, 1'b1, 0);
        @(posedge clk); #1;
        inv_req = 1'b1; inv_index = 7'd0;
        sif.sram_req = 1'b1; sif.sram_addr = 32'h0000_3000; sif.sram_cache = 1'b1;
        @(negedge clk);
        check("t6 inv_ack", 32'(inv_ack), 32'd1);
        check("t6 inv addr_ok", 32'(sif.sram_addr_ok), 32'd0);
        @(posedge clk); #1 inv_req = 1'b0; sif.sram_req = 1'b0;
        fetch("t6 miss after inv", 32'h0000_2000, 1'b1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
